// File: rtl/wb_router.sv
// Write-back steering: routes each accepted result word to the register-file
// write port or the stallable data-memory write port. Optional counters: WB_ROUTER_STATS_EN.
module wb_router #(
  parameter int DW         = 16,
  parameter int RF_AW      = 4,
  parameter int DM_AW      = 8,
  parameter int DM_TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [DM_AW-1:0] in_addr,
  input  logic [DW-1:0]    in_data,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [DW-1:0]    dm_wdata,
  input  logic             dm_ready,
  output logic             err
`ifdef WB_ROUTER_STATS_EN
  ,
  output logic [15:0]      rf_count,
  output logic [15:0]      dm_count,
  output logic [7:0]       to_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RF_WR = 2'd1,
    DM_WR = 2'd2
  } state_t;

  // Wait counter only has to reach DM_TIMEOUT-1; with DM_TIMEOUT=0 it just wraps.
  localparam int            CW      = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((DM_TIMEOUT > 0) ? (DM_TIMEOUT - 1) : 0);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rf_we_d, dm_we_d, err_d;
  logic [RF_AW-1:0] rf_waddr_d;
  logic [DW-1:0]    rf_wdata_d, dm_wdata_d;
  logic [DM_AW-1:0] dm_addr_d;
  logic             timeout_hit;

  assign in_ready    = (state_q == IDLE);
  assign timeout_hit = (DM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rf_we_d    = 1'b0;
    dm_we_d    = dm_we;
    err_d      = 1'b0;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;
    dm_addr_d  = dm_addr;
    dm_wdata_d = dm_wdata;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!in_sel) begin
            rf_waddr_d = in_addr[RF_AW-1:0];
            rf_wdata_d = in_data;
            rf_we_d    = 1'b1;
            state_d    = RF_WR;
          end else begin
            dm_addr_d  = in_addr;
            dm_wdata_d = in_data;
            dm_we_d    = 1'b1;
            cnt_d      = '0;
            state_d    = DM_WR;
          end
        end
      end

      RF_WR: begin
        state_d = IDLE;
      end

      DM_WR: begin
        // An acknowledge on the expiry edge still counts as a completed write.
        if (dm_ready) begin
          dm_we_d = 1'b0;
          state_d = IDLE;
        end else if (timeout_hit) begin
          dm_we_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        dm_we_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rf_we    <= 1'b0;
      dm_we    <= 1'b0;
      err      <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rf_we    <= rf_we_d;
      dm_we    <= dm_we_d;
      err      <= err_d;
      rf_waddr <= rf_waddr_d;
      rf_wdata <= rf_wdata_d;
      dm_addr  <= dm_addr_d;
      dm_wdata <= dm_wdata_d;
    end
  end

`ifdef WB_ROUTER_STATS_EN
  // Counters step on the edge that completes the write or the timeout.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rf_count <= '0;
      dm_count <= '0;
      to_count <= '0;
    end else begin
      if (state_q == RF_WR)
        rf_count <= rf_count + 16'd1;
      if (state_q == DM_WR && dm_ready)
        dm_count <= dm_count + 16'd1;
      if (state_q == DM_WR && !dm_ready && timeout_hit)
        to_count <= to_count + 8'd1;
    end
  end
`endif

  a_one_dest: assert property (@(posedge Clk) disable iff (!ResetN) !(rf_we && dm_we));
  a_err_pulse: assert property (@(posedge Clk) disable iff (!ResetN) err |=> !err);

endmodule

// File: tb/tb_wb_router.sv
// Randomized scoreboard bench for wb_router: a stimulus process pushes expected
// write events, a monitor pops and compares them as the DUT emits writes.
module tb_wb_router;

  localparam int DW         = 16;
  localparam int RF_AW      = 4;
  localparam int DM_AW      = 8;
  localparam int DM_TIMEOUT = 15;

  logic             Clk;
  logic             ResetN;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [DM_AW-1:0] in_addr;
  logic [DW-1:0]    in_data;
  logic             rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [DW-1:0]    dm_wdata;
  logic             dm_ready;
  logic             err;
`ifdef WB_ROUTER_STATS_EN
  logic [15:0]      rf_count;
  logic [15:0]      dm_count;
  logic [7:0]       to_count;
`endif

  wb_router #(
    .DW(DW), .RF_AW(RF_AW), .DM_AW(DM_AW), .DM_TIMEOUT(DM_TIMEOUT)
  ) dut (
    .Clk(Clk), .ResetN(ResetN),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_addr(in_addr), .in_data(in_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .err(err)
`ifdef WB_ROUTER_STATS_EN
    , .rf_count(rf_count), .dm_count(dm_count), .to_count(to_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One expected write event per accepted word.
  typedef struct {
    bit          is_dm;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cycles;
    bit          timeout;
  } exp_t;

  exp_t exp_q[$];
  int   stall_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   m_rf = 0, m_dm = 0, m_to = 0;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a DM write with 'stall' low-ready cycles is acknowledged
  // after stall+1 cycles of dm_we, unless that exceeds the timeout window.
  task automatic send(input logic sel, input logic [7:0] addr, input logic [15:0] data,
                      input int stall, output int acc_cyc);
    exp_t e;
    int   guard;
    in_valid = 1'b1;
    in_sel   = sel;
    in_addr  = addr;
    in_data  = data;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_wait", in_ready, 1);
      in_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    e.is_dm = sel;
    e.addr  = addr;
    e.data  = data;
    if (sel) begin
      e.timeout = (stall >= DM_TIMEOUT);
      e.cycles  = e.timeout ? DM_TIMEOUT : stall + 1;
      stall_q.push_back(stall);
      if (e.timeout) m_to++; else m_dm++;
    end else begin
      e.timeout = 1'b0;
      e.cycles  = 1;
      m_rf++;
    end
    exp_q.push_back(e);
    acc_cyc = cyc;
    @(negedge Clk);
    in_valid = 1'b0;
    in_sel   = 1'($urandom);
    in_addr  = 8'($urandom);
    in_data  = 16'($urandom);
  endtask

  // Memory model: holds dm_ready low for the stall chosen for this write.
  initial begin
    bit busy;
    int rem;
    dm_ready = 1'b0;
    busy = 1'b0;
    rem  = 0;
    forever begin
      @(negedge Clk);
      if (!ResetN) begin
        busy = 1'b0;
        dm_ready = 1'b0;
      end else if (dm_we) begin
        if (!busy) begin
          busy = 1'b1;
          rem  = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        end
        dm_ready = (rem == 0);
        if (rem > 0) rem--;
      end else begin
        busy = 1'b0;
        dm_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares every emitted write against the scoreboard head.
  initial begin
    bit   prev_rf_we, prev_dm_we;
    int   dm_cycles;
    exp_t e, cur;
    prev_rf_we = 0;
    prev_dm_we = 0;
    dm_cycles  = 0;
    forever begin
      @(negedge Clk);
      if (!ResetN) begin
        prev_rf_we = 0;
        prev_dm_we = 0;
        dm_cycles  = 0;
      end else begin
        check("in_ready_idle", in_ready, !(rf_we || dm_we));
        if (rf_we) begin
          check("rf_we_pulse", prev_rf_we, 0);
          check("exp_avail_rf", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_route", rf_we && !e.is_dm, 1);
            check("rf_waddr", rf_waddr, e.addr[3:0]);
            check("rf_wdata", rf_wdata, e.data);
          end
        end
        if (dm_we && !prev_dm_we) begin
          check("exp_avail_dm", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("dm_route", dm_we && cur.is_dm, 1);
            check("dm_addr", dm_addr, cur.addr);
            check("dm_wdata", dm_wdata, cur.data);
          end
          dm_cycles = 1;
        end else if (dm_we) begin
          check("dm_addr_hold", dm_addr, cur.addr);
          check("dm_wdata_hold", dm_wdata, cur.data);
          dm_cycles++;
        end
        if (!dm_we && prev_dm_we) begin
          check("dm_we_cycles", dm_cycles, cur.cycles);
          check("dm_err", err, cur.timeout);
        end else if (err) begin
          check("err_spurious", err, 0);
        end
        prev_rf_we = rf_we;
        prev_dm_we = dm_we;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, guard;
    ResetN   = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    repeat (3) @(negedge Clk);
    #3 ResetN = 1'b1;
    @(negedge Clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_err", err, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);

    // Directed cases: RF route, stalled DM, timeout, ack on the expiry edge.
    send(1'b0, 8'h3A, 16'hBEEF, 0, a0);
    send(1'b1, 8'h80, 16'h1234, 3, a0);
    send(1'b1, 8'h11, 16'h5555, 20, a0);
    send(1'b1, 8'h22, 16'hAAAA, 14, a0);
    send(1'b1, 8'h33, 16'h0F0F, 15, a0);

    // Back-to-back with in_valid held: one word per two cycles.
    send(1'b0, 8'hF1, 16'h1111, 0, a0);
    send(1'b1, 8'h42, 16'h2222, 0, a1);
    send(1'b0, 8'h07, 16'h3333, 0, a2);
    check("b2b_gap_1", a1 - a0, 2);
    check("b2b_gap_2", a2 - a1, 2);

    // Reset in the middle of a stalled DM write.
    send(1'b1, 8'h44, 16'h7777, 50, a0);
    repeat (4) @(negedge Clk);
    check("pre_rst_dm_we", dm_we, 1);
    #2 ResetN = 1'b0;
    #1;
    check("async_rst_dm_we", dm_we, 0);
    check("async_rst_dm_addr", dm_addr, 0);
    check("rst_pending_exp", exp_q.size(), 0);
    m_rf = 0; m_dm = 0; m_to = 0;
    @(negedge Clk);
    #3 ResetN = 1'b1;
    @(negedge Clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_dm_we", dm_we, 0);
    check("rel_dm_wdata", dm_wdata, 0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic sel;
      int   stall;
      sel   = 1'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20))
                                          : int'($urandom_range(0, 4));
      send(sel, 8'($urandom), 16'($urandom), stall, a0);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    guard = 0;
    while ((exp_q.size() > 0 || !in_ready) && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    @(negedge Clk);
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_in_ready", in_ready, 1);
`ifdef WB_ROUTER_STATS_EN
    check("rf_count", rf_count, m_rf & 32'hFFFF);
    check("dm_count", dm_count, m_dm & 32'hFFFF);
    check("to_count", to_count, m_to & 32'hFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
